blur_seq_ctrl: RTL and testbench
================================

Name: blur_seq_ctrl

Overview:
- Sequencer between a 24-bit RGB pixel source and the 5x5 Gaussian blur datapath.
- Accepts one packed RGB pixel per handshake and issues it to the datapath as three byte-wide colours (R, G, B) on consecutive cycles.
- Tracks raster column/row, drives row_end, captures the datapath's blurred bytes at a fixed latency, and repacks them into 24-bit output pixels.
- Suppresses outputs while the window is still filling at the start of each row, and signals frame completion.

Parameters:
- IMG_W, 640, pixels per row (must be > WARM).
- IMG_H, 480, rows per frame.
- WARM, 24, per-row column index of the first pixel whose result is emitted.
- BLUR_LAT, 2, cycles from a colour issue to its blurred byte on i_blur_pixel (≥1).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  pulse that arms a frame; ignored unless in IDLE.
- i_pix_valid  in  1  source pixel valid.
- o_pix_ready  out  1  source handshake ready.
- i_pix_rgb  in  24  {R[23:16],G[15:8],B[7:0]}.
- o_blur_valid  out  1  to datapath i_valid.
- o_blur_row_end  out  1  to datapath i_row_end.
- o_blur_pixel  out  8  to datapath i_pixel.
- i_blur_pixel  in  8  datapath o_pixel.
- o_out_valid  out  1  blurred pixel valid.
- i_out_ready  in  1  sink ready.
- o_out_rgb  out  24  blurred pixel, same packing as input.
- o_frame_done  out  1  one-cycle pulse at frame end.
- o_busy  out  1  state != IDLE.

Behaviour:
- Reset (async, i_rst_n=0):
  - All outputs 0. State IDLE. col/row counters 0. Issue-tag pipe cleared. Output register empty.
  - Reset mid-frame abandons the frame; no frame_done.
- FSM states: IDLE, WAIT_PIX, ISSUE_R, ISSUE_G, ISSUE_B, DRAIN.
- IDLE:
  - i_start -> WAIT_PIX.
  - An i_start while the FSM is in any other state is ignored.
- WAIT_PIX:
  - o_pix_ready = (!o_out_valid || i_out_ready).
  - On i_pix_valid && o_pix_ready: latch i_pix_rgb, go to ISSUE_R.
- ISSUE_R/G/B:
  - One cycle each.
  - o_blur_valid=1; o_blur_pixel = latched R/G/B respectively.
  - o_blur_row_end = (col == IMG_W-1) in all three cycles.
  - A colour tag enters the tag pipe on each issue cycle.
- DRAIN:
  - Hold for BLUR_LAT-1 cycles (counter); then
    - if the pixel was the last of the frame: pulse o_frame_done, go to IDLE;
    - otherwise go to WAIT_PIX.
- Capture:
  - A tag issued in cycle c samples i_blur_pixel at cycle c+BLUR_LAT into the R/G/B byte slot.
  - Capture of the B byte completes the pixel.
  - If the completing pixel's col ≥ WARM: the output register loads and o_out_valid=1 the next cycle.
  - Otherwise the pixel is discarded silently.
- Output register:
  - Holds value and valid until i_out_ready.
  - Never overwritten while full: the o_pix_ready rule guarantees the register is empty when the next result lands.
- Counters:
  - col increments at the end of ISSUE_B. It wraps to 0 at IMG_W-1, which also increments row.
  - row wraps to 0 after IMG_H-1, together with the frame_done path.
  - Counter widths are $clog2 of the parameter.
- Timing (BLUR_LAT=2):
  - Accept at A; issues at A+1..A+3; B captured at A+5; o_out_valid at A+6.
  - The next accept is possible at A+6, giving a throughput of 1 pixel per 6 cycles.
- o_frame_done and o_out_valid of the last pixel rise in the same cycle.
- o_frame_done never coincides with o_pix_ready.

Decomposition:
- Package blur_pkg:
  - typedef of state enum;
  - typedef colour_e {RED=0, GREEN=1, BLUE=2}, shared with the blur datapath;
  - RGB field offset constants.
- One sub-module: blur_tag_pipe.
  - Parameterised BLUR_LAT-deep shift of {valid, colour, last, emit} tags.
  - Produces the capture strobes.

Test Plan:
- Single row, IMG_W=28, IMG_H=1, constant pixel 0x404040, sink always ready:
  - exactly 4 outputs (cols 24..27), each 0x404040;
  - o_frame_done pulses with the 4th output;
  - FSM returns to IDLE.
- Timing check, accept at cycle A:
  - o_blur_valid high A+1..A+3 with bytes R, G, B in order;
  - o_out_valid rises at A+6;
  - o_blur_row_end high only for col 27 issues.
- Backpressure: hold i_out_ready=0 for 10 cycles after the first output:
  - o_pix_ready stays 0;
  - o_out_rgb is stable;
  - no byte is lost;
  - on release, the sequence resumes correctly.
- IMG_W=28, IMG_H=2 with a ramp input:
  - row increments after col 27;
  - 8 total outputs;
  - the output count matches (IMG_W-WARM)*IMG_H.
- Pulse i_start mid-frame:
  - ignored; counters unaffected.
- Assert i_rst_n=0 during ISSUE_G:
  - all outputs 0 immediately;
  - no frame_done;
  - a new i_start runs a clean frame.

Source files
------------

// File: rtl/blur_pkg.sv
// Shared types for the blur sequencer and the blur datapath.
package blur_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PIX,
    ISSUE_R,
    ISSUE_G,
    ISSUE_B,
    DRAIN
  } state_e;

  typedef enum logic [1:0] {
    RED   = 2'd0,
    GREEN = 2'd1,
    BLUE  = 2'd2
  } colour_e;

  // Byte offsets inside a packed {R,G,B} pixel
  localparam int unsigned R_OFS = 16;
  localparam int unsigned G_OFS = 8;
  localparam int unsigned B_OFS = 0;

  typedef struct packed {
    logic    valid;
    colour_e colour;
    logic    last;
    logic    emit;
  } tag_t;

endpackage

// File: rtl/blur_tag_pipe.sv
// Delays one issue tag per colour by DEPTH cycles so that each colour
// samples the datapath output exactly when its blurred byte appears.
module blur_tag_pipe
  import blur_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  logic [1:0] i_colour,
  input  logic       i_last,
  input  logic       i_emit,
  output logic       o_cap_r,
  output logic       o_cap_g,
  output logic       o_cap_b,
  output logic       o_last,
  output logic       o_emit
);

  tag_t pipe_q [DEPTH];
  tag_t tail;

  // Shift tags one stage per cycle; stage DEPTH-1 is the capture point
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= '{valid: i_valid, colour: colour_e'(i_colour), last: i_last, emit: i_emit};
      for (int unsigned i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tail    = pipe_q[DEPTH-1];
  assign o_cap_r = tail.valid && (tail.colour == RED);
  assign o_cap_g = tail.valid && (tail.colour == GREEN);
  assign o_cap_b = tail.valid && (tail.colour == BLUE);
  assign o_last  = tail.last;
  assign o_emit  = tail.emit;

endmodule

// File: rtl/blur_seq_ctrl.sv
// Sequencer between a 24-bit RGB source and the byte-wide 5x5 blur datapath:
// serialises each pixel into R/G/B issues, tracks raster position, captures
// blurred bytes at fixed latency and repacks them into output pixels.
module blur_seq_ctrl
  import blur_pkg::*;
#(
  parameter int unsigned IMG_W    = 640,
  parameter int unsigned IMG_H    = 480,
  parameter int unsigned WARM     = 24,
  parameter int unsigned BLUR_LAT = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_pix_valid,
  output logic        o_pix_ready,
  input  logic [23:0] i_pix_rgb,
  output logic        o_blur_valid,
  output logic        o_blur_row_end,
  output logic [7:0]  o_blur_pixel,
  input  logic [7:0]  i_blur_pixel,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [23:0] o_out_rgb,
  output logic        o_frame_done,
  output logic        o_busy
);

  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned DW = (BLUR_LAT > 1) ? $clog2(BLUR_LAT) : 1;

  state_e        state_q, state_d;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [DW-1:0] drain_q;
  logic [23:0]   pix_q;
  logic [7:0]    r_q, g_q;
  logic [23:0]   out_rgb_q;
  logic          out_valid_q;
  logic          done_q;

  logic          accept, issue, done_set;
  logic          col_last, row_last;
  colour_e       issue_col;
  logic          cap_r, cap_g, cap_b, cap_last, cap_emit;

  assign col_last       = (col_q == CW'(IMG_W - 1));
  assign row_last       = (row_q == RW'(IMG_H - 1));
  assign o_blur_valid   = issue;
  assign o_blur_row_end = issue && col_last;
  assign o_out_valid    = out_valid_q;
  assign o_out_rgb      = out_rgb_q;
  assign o_frame_done   = done_q;
  assign o_busy         = (state_q != IDLE);

  blur_tag_pipe #(.DEPTH(BLUR_LAT)) u_tag_pipe (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (issue),
    .i_colour (issue_col),
    .i_last   (col_last && row_last),
    .i_emit   (col_q >= CW'(WARM)),
    .o_cap_r  (cap_r),
    .o_cap_g  (cap_g),
    .o_cap_b  (cap_b),
    .o_last   (cap_last),
    .o_emit   (cap_emit)
  );

  // Next-state and issue decode
  always_comb begin
    state_d      = state_q;
    o_pix_ready  = 1'b0;
    accept       = 1'b0;
    issue        = 1'b0;
    issue_col    = RED;
    o_blur_pixel = '0;
    done_set     = 1'b0;
    case (state_q)
      IDLE: if (i_start) state_d = WAIT_PIX;
      WAIT_PIX: begin
        o_pix_ready = !out_valid_q || i_out_ready;
        accept      = i_pix_valid && o_pix_ready;
        if (accept) state_d = ISSUE_R;
      end
      ISSUE_R: begin
        issue        = 1'b1;
        issue_col    = RED;
        o_blur_pixel = pix_q[R_OFS +: 8];
        state_d      = ISSUE_G;
      end
      ISSUE_G: begin
        issue        = 1'b1;
        issue_col    = GREEN;
        o_blur_pixel = pix_q[G_OFS +: 8];
        state_d      = ISSUE_B;
      end
      ISSUE_B: begin
        issue        = 1'b1;
        issue_col    = BLUE;
        o_blur_pixel = pix_q[B_OFS +: 8];
        state_d      = DRAIN;
      end
      DRAIN: begin
        // Leave on the cycle the B byte is captured, so the next accept
        // lines up with o_out_valid and the register can never be overwritten.
        if (drain_q == DW'(BLUR_LAT - 1)) begin
          if (cap_last) begin
            state_d  = IDLE;
            done_set = 1'b1;
          end else begin
            state_d = WAIT_PIX;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pixel latch, drain counter and raster counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      pix_q   <= '0;
      drain_q <= '0;
      col_q   <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_set;
      if (accept) pix_q <= i_pix_rgb;
      if (state_q == DRAIN && state_d == DRAIN) drain_q <= drain_q + 1'b1;
      else                                      drain_q <= '0;
      if (state_q == ISSUE_B) begin
        if (col_last) begin
          col_q <= '0;
          row_q <= row_last ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

  // Capture blurred bytes and hold the repacked pixel until the sink takes it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q         <= '0;
      g_q         <= '0;
      out_rgb_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (cap_r) r_q <= i_blur_pixel;
      if (cap_g) g_q <= i_blur_pixel;
      if (cap_b && cap_emit) begin
        out_rgb_q   <= {r_q, g_q, i_blur_pixel};
        out_valid_q <= 1'b1;
      end else if (out_valid_q && i_out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_blur_seq_ctrl.sv
// Self-checking bench for blur_seq_ctrl with a small fake blur datapath
// and a pixel-level reference model.
module tb_blur_seq_ctrl;

  localparam int unsigned IMG_W = 28;
  localparam int unsigned IMG_H = 2;
  localparam int unsigned WARM  = 24;
  localparam int unsigned LAT   = 2;
  localparam int unsigned TOTAL = IMG_W * IMG_H;
  localparam int unsigned N_OUT = (IMG_W - WARM) * IMG_H;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic        i_pix_valid = 1'b0;
  logic        i_out_ready = 1'b1;
  logic [23:0] i_pix_rgb = '0;
  logic [7:0]  i_blur_pixel;
  logic        o_pix_ready, o_blur_valid, o_blur_row_end, o_out_valid, o_frame_done, o_busy;
  logic [7:0]  o_blur_pixel;
  logic [23:0] o_out_rgb;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  blur_seq_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .WARM(WARM), .BLUR_LAT(LAT)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_start        (i_start),
    .i_pix_valid    (i_pix_valid),
    .o_pix_ready    (o_pix_ready),
    .i_pix_rgb      (i_pix_rgb),
    .o_blur_valid   (o_blur_valid),
    .o_blur_row_end (o_blur_row_end),
    .o_blur_pixel   (o_blur_pixel),
    .i_blur_pixel   (i_blur_pixel),
    .o_out_valid    (o_out_valid),
    .i_out_ready    (i_out_ready),
    .o_out_rgb      (o_out_rgb),
    .o_frame_done   (o_frame_done),
    .o_busy         (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] dp_f(input logic [7:0] x);
    return {x[3:0], x[7:4]} ^ 8'h3C;
  endfunction

  function automatic logic [23:0] blur_rgb(input logic [23:0] p);
    return {dp_f(p[23:16]), dp_f(p[15:8]), dp_f(p[7:0])};
  endfunction

  function automatic logic [7:0] byte_at(input logic [23:0] p, input int unsigned k);
    case (k)
      1:       return p[23:16];
      2:       return p[15:8];
      default: return p[7:0];
    endcase
  endfunction

  // Fake datapath: fixed 2-cycle latency, garbage when nothing is due
  logic [7:0] dp_d1 = '0, dp_d2 = '0, junk = '0;
  logic       dp_v1 = 1'b0, dp_v2 = 1'b0;
  always @(posedge i_clk) begin
    dp_d1 <= o_blur_pixel;
    dp_v1 <= o_blur_valid;
    dp_d2 <= dp_d1;
    dp_v2 <= dp_v1;
    junk  <= 8'($urandom);
  end
  assign i_blur_pixel = dp_v2 ? dp_f(dp_d2) : junk;

  // Reference model state
  int unsigned acc_cnt = 0, out_cnt = 0, done_cnt = 0, sa = 0;
  bit          tracking = 0, prev_stall = 0, prev_ov = 0;
  logic [23:0] cur_pix = '0, prev_rgb = '0;
  logic [23:0] exp_q[$];

  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      acc_cnt = 0; sa = 0; tracking = 0; prev_stall = 0; prev_ov = 0;
      exp_q.delete();
    end else begin
      if (tracking) begin
        sa++;
        check("blur_valid", 32'(o_blur_valid), 32'((sa >= 1) && (sa <= 3)));
        check("row_end", 32'(o_blur_row_end),
              32'((sa >= 1) && (sa <= 3) && (((acc_cnt - 1) % IMG_W) == IMG_W - 1)));
        if (sa >= 1 && sa <= 3)
          check("blur_byte", 32'(o_blur_pixel), 32'(byte_at(cur_pix, sa)));
        if (o_out_valid && !prev_ov)
          check("out_latency", sa, LAT + 4);
      end
      if (prev_stall) begin
        check("hold_valid", 32'(o_out_valid), 32'd1);
        check("hold_rgb", 32'(o_out_rgb), 32'(prev_rgb));
      end
      if (o_out_valid && !i_out_ready)
        check("pix_ready_bp", 32'(o_pix_ready), 32'd0);
      if (o_frame_done) begin
        done_cnt++;
        check("done_with_out", 32'(o_out_valid), 32'd1);
        check("done_accepts", acc_cnt, TOTAL);
        check("done_pending", exp_q.size(), 32'd1);
        check("done_vs_ready", 32'(o_pix_ready), 32'd0);
      end
      if (o_out_valid && i_out_ready) begin
        check("out_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("out_rgb", 32'(o_out_rgb), 32'(exp_q.pop_front()));
        out_cnt++;
      end
      if (o_pix_ready && i_pix_valid) begin
        if (acc_cnt == TOTAL) acc_cnt = 0;
        acc_cnt++;
        cur_pix = i_pix_rgb;
        if (((acc_cnt - 1) % IMG_W) >= WARM) exp_q.push_back(blur_rgb(i_pix_rgb));
        sa = 0;
        tracking = 1;
      end
      prev_stall = o_out_valid && !i_out_ready;
      prev_rgb   = o_out_rgb;
      prev_ov    = o_out_valid;
    end
  end

  task automatic check_all_zero(input string t);
    check({t, "_pix_ready"}, 32'(o_pix_ready), 32'd0);
    check({t, "_blur_valid"}, 32'(o_blur_valid), 32'd0);
    check({t, "_row_end"}, 32'(o_blur_row_end), 32'd0);
    check({t, "_blur_pixel"}, 32'(o_blur_pixel), 32'd0);
    check({t, "_out_valid"}, 32'(o_out_valid), 32'd0);
    check({t, "_out_rgb"}, 32'(o_out_rgb), 32'd0);
    check({t, "_frame_done"}, 32'(o_frame_done), 32'd0);
    check({t, "_busy"}, 32'(o_busy), 32'd0);
  endtask

  // mode: 0 random pixels, 1 constant 0x404040, 2 ramp
  task automatic run_frame(input int unsigned mode, input bit bp, input bit start_noise);
    int unsigned o0 = out_cnt, d0 = done_cnt, bp_left = 0;
    bit bp_done = 0, finished = 0;
    @(posedge i_clk); #1; i_start = 1'b1;
    @(posedge i_clk); #1; i_start = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (done_cnt != d0) begin finished = 1; break; end
      i_pix_valid = ($urandom_range(0, 3) != 0);
      case (mode)
        1:       i_pix_rgb = 24'h404040;
        2:       i_pix_rgb = {8'(acc_cnt), 8'(acc_cnt * 3), 8'(255 - acc_cnt)};
        default: i_pix_rgb = 24'($urandom);
      endcase
      if (bp && !bp_done && out_cnt == o0 + 1) begin bp_left = 10; bp_done = 1; end
      if (bp_left > 0) begin i_out_ready = 1'b0; bp_left--; end
      else if (mode == 0) i_out_ready = ($urandom_range(0, 3) != 0);
      else i_out_ready = 1'b1;
      i_start = start_noise && (acc_cnt > 0) && (acc_cnt < TOTAL) && ($urandom_range(0, 7) == 0);
      @(posedge i_clk); #1;
    end
    i_pix_valid = 1'b0;
    i_start     = 1'b0;
    i_out_ready = 1'b1;
    check("frame_finished", 32'(finished), 32'd1);
    repeat (3) @(posedge i_clk);
    #1;
    check("frame_out_count", out_cnt - o0, N_OUT);
    check("frame_done_pulses", done_cnt - d0, 32'd1);
    check("frame_queue_empty", exp_q.size(), 32'd0);
    check("frame_idle", 32'(o_busy), 32'd0);
  endtask

  task automatic reset_mid_frame();
    int unsigned d0 = done_cnt;
    bit found = 0;
    @(posedge i_clk); #1; i_start = 1'b1;
    @(posedge i_clk); #1; i_start = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (acc_cnt == 30) begin found = 1; break; end
      i_pix_valid = 1'b1;
      i_pix_rgb   = 24'($urandom);
      i_out_ready = 1'b1;
      @(posedge i_clk); #1;
    end
    i_pix_valid = 1'b0;
    check("rst_reach_pixel", 32'(found), 32'd1);
    // Now in the first issue cycle of pixel 30; one more cycle reaches the G issue
    @(posedge i_clk); #1;
    check("rst_issue_g", 32'(o_blur_pixel), 32'(cur_pix[15:8]));
    i_rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    repeat (3) @(posedge i_clk);
    #1; i_rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge i_clk); #1;
      check("rst_no_done", 32'(o_frame_done), 32'd0);
    end
    check("rst_done_count", done_cnt - d0, 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check_all_zero("reset");
    i_rst_n = 1'b1;
    run_frame(1, 1'b0, 1'b0);
    run_frame(2, 1'b1, 1'b1);
    run_frame(0, 1'b0, 1'b1);
    reset_mid_frame();
    run_frame(0, 1'b1, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
